// File: rtl/grabber_scheduler_pkg.sv
// Shared types and constants for the grabber harvest scheduler.
package grabber_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_START,
    S_WAIT_RPT,
    S_PASS,
    S_NEXT,
    S_ERR
  } gs_state_t;

  localparam logic [7:0] GS_HDR_BASE = 8'hA0;
  localparam logic [7:0] GS_ERR_BYTE = 8'hEE;

  function automatic logic [7:0] gs_hdr_byte(input logic [3:0] sel);
    return GS_HDR_BASE | {4'h0, sel};
  endfunction

endpackage

// File: rtl/gs_prio_pick.sv
// Lowest-set-bit finder: returns the index of the lowest set bit and an any flag.
module gs_prio_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i] && !any_o) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grabber_scheduler.sv
// Harvest sequencer / byte arbiter for a bank of stream_grabber instances.
// Define GRABBER_SCHEDULER_HEADER_EN to frame each grabber dump with an 0xA0|sel header byte.
module grabber_scheduler
  import grabber_scheduler_pkg::*;
#(
  parameter int unsigned NUM_GRABBERS = 4,
  parameter int unsigned TIMEOUT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      harvest_req,
  input  logic [NUM_GRABBERS-1:0]   enable_mask,
  output logic                      busy,
  output logic [NUM_GRABBERS-1:0]   start_harvest,
  input  logic [NUM_GRABBERS-1:0]   reporting,
  input  logic [8*NUM_GRABBERS-1:0] byte_in,
  input  logic [NUM_GRABBERS-1:0]   byte_in_valid,
  output logic [NUM_GRABBERS-1:0]   byte_in_ready,
  output logic [7:0]                byte_out,
  output logic                      byte_out_valid,
  input  logic                      byte_out_ready,
  output logic                      timeout_err
);

  localparam int unsigned SW = $clog2(NUM_GRABBERS);
  localparam logic [NUM_GRABBERS-1:0] ONE = NUM_GRABBERS'(1);

`ifdef GRABBER_SCHEDULER_HEADER_EN
  localparam bit HeaderEn = 1'b1;
`else
  localparam bit HeaderEn = 1'b0;
`endif

  localparam gs_state_t FirstState = HeaderEn ? S_HEADER : S_START;

  gs_state_t               state_q, state_d;
  logic [NUM_GRABBERS-1:0] mask_q, mask_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
  logic [7:0]              out_q, out_d;
  logic                    out_vld_q, out_vld_d;
  logic                    terr_q, terr_d;

  logic [7:0]              in_byte [NUM_GRABBERS];
  logic [NUM_GRABBERS-1:0] sel_onehot;
  logic [NUM_GRABBERS-1:0] pick_vec;
  logic [SW-1:0]           pick_idx;
  logic                    pick_any;
  logic                    slot_free;
  logic                    cur_rpt;
  logic                    cur_vld;

  always_comb begin
    for (int unsigned i = 0; i < NUM_GRABBERS; i++) begin
      in_byte[i] = byte_in[8*i +: 8];
    end
  end

  assign sel_onehot = ONE << sel_q;
  assign slot_free  = !out_vld_q || byte_out_ready;
  assign cur_rpt    = reporting[sel_q];
  assign cur_vld    = byte_in_valid[sel_q];

  // One finder serves both IDLE (fresh mask) and NEXT (mask minus the grabber just finished).
  assign pick_vec = (state_q == S_IDLE) ? enable_mask : (mask_q & ~sel_onehot);

  gs_prio_pick #(
    .N  (NUM_GRABBERS),
    .IW (SW)
  ) u_pick (
    .vec_i (pick_vec),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    sel_d         = sel_q;
    wdog_d        = wdog_q;
    out_d         = out_q;
    out_vld_d     = out_vld_q && !byte_out_ready;
    terr_d        = terr_q;
    start_harvest = '0;
    byte_in_ready = '0;

    case (state_q)
      S_IDLE: begin
        if (harvest_req) begin
          mask_d = enable_mask;
          terr_d = 1'b0;
          sel_d  = pick_idx;
          if (pick_any) begin
            state_d = FirstState;
          end
        end
      end

      S_HEADER: begin
        if (slot_free) begin
          out_d     = gs_hdr_byte(4'(sel_q));
          out_vld_d = 1'b1;
          state_d   = S_START;
        end
      end

      S_START: begin
        start_harvest = sel_onehot;
        wdog_d        = '0;
        state_d       = S_WAIT_RPT;
      end

      S_WAIT_RPT: begin
        if (cur_rpt) begin
          state_d = S_PASS;
        end else if (wdog_q == '1) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_PASS: begin
        byte_in_ready = sel_onehot & {NUM_GRABBERS{slot_free}};
        // Reporting was high on entry, so low here is the falling edge; a byte
        // still offered alongside it is drained before moving on.
        if (cur_vld && slot_free) begin
          out_d     = in_byte[sel_q];
          out_vld_d = 1'b1;
        end else if (!cur_rpt && !cur_vld) begin
          state_d = S_NEXT;
        end
      end

      S_ERR: begin
        if (slot_free) begin
          out_d     = GS_ERR_BYTE;
          out_vld_d = 1'b1;
          terr_d    = 1'b1;
          state_d   = S_NEXT;
        end
      end

      S_NEXT: begin
        mask_d = mask_q & ~sel_onehot;
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = FirstState;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      sel_q     <= '0;
      wdog_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      wdog_q    <= wdog_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      terr_q    <= terr_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign byte_out       = out_q;
  assign byte_out_valid = out_vld_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_grabber_scheduler.sv
// Self-checking bench for grabber_scheduler with behavioural grabbers and a pass-level reference model.
module tb_grabber_scheduler;

  localparam int NG = 4;
  localparam int TB = 8;

  logic            clk = 1'b0;
  logic            arst;
  logic            harvest_req;
  logic [NG-1:0]   enable_mask;
  logic            busy;
  logic [NG-1:0]   start_harvest;
  logic [NG-1:0]   reporting;
  logic [8*NG-1:0] byte_in;
  logic [NG-1:0]   byte_in_valid;
  logic [NG-1:0]   byte_in_ready;
  logic [7:0]      byte_out;
  logic            byte_out_valid;
  logic            byte_out_ready;
  logic            timeout_err;

  always #5 clk = ~clk;

  grabber_scheduler #(
    .NUM_GRABBERS (NG),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .harvest_req    (harvest_req),
    .enable_mask    (enable_mask),
    .busy           (busy),
    .start_harvest  (start_harvest),
    .reporting      (reporting),
    .byte_in        (byte_in),
    .byte_in_valid  (byte_in_valid),
    .byte_in_ready  (byte_in_ready),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .timeout_err    (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Grabber models: st 0 idle, 1 started/awaiting report, 2 reporting.
  logic [7:0] gq [NG][$];
  int         g_st   [NG];
  int         g_dly  [NG];
  bit         g_alive[NG];
  bit         g_held [NG];

  logic [7:0]    obs[$];
  int            start_cnt[NG];
  bit            pend_out;
  logic [7:0]    pend_byte;
  logic [NG-1:0] pend_in, pend_start;
  bit            prev_hold;
  logic [7:0]    prev_byte;
  int            stab_err, rdy_err, active;
  logic [NG-1:0] noise_mask;
  int            rdy_mode;
  bit            req_next;
  logic [NG-1:0] req_mask;

  function automatic logic [NG-1:0] oh(input int i);
    logic [NG-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    logic [NG-1:0]   v_vec, r_vec;
    logic [8*NG-1:0] b_vec;
    logic            v;
    logic [7:0]      b;
    @(negedge clk);
    if (pend_out) obs.push_back(pend_byte);
    for (int i = 0; i < NG; i++) begin
      if (pend_in[i] && gq[i].size() > 0) begin
        void'(gq[i].pop_front());
        g_held[i] = 1'b0;
      end
      if (pend_start[i]) begin
        g_st[i]  = 1;
        g_dly[i] = $urandom_range(0, 3);
        active   = i;
      end else if (g_st[i] == 1 && g_alive[i]) begin
        if (g_dly[i] == 0) g_st[i] = 2;
        else g_dly[i]--;
      end else if (g_st[i] == 2 && gq[i].size() == 0) begin
        g_st[i] = 0;
      end
    end
    for (int i = 0; i < NG; i++) begin
      if (g_st[i] == 2 && gq[i].size() > 0) begin
        v = g_held[i] || ($urandom_range(0, 3) != 0);
        b = gq[i][0];
      end else if (noise_mask[i]) begin
        v = 1'($urandom_range(0, 1));
        b = 8'($urandom);
      end else begin
        v = 1'b0;
        b = 8'h00;
      end
      r_vec[i]        = (g_st[i] == 2);
      v_vec[i]        = v;
      b_vec[8*i +: 8] = b;
      g_held[i]       = v;
    end
    reporting      = r_vec;
    byte_in_valid  = v_vec;
    byte_in        = b_vec;
    byte_out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    harvest_req    = req_next;
    enable_mask    = req_mask;
    req_next       = 1'b0;
    #1;
    if (prev_hold && !(byte_out_valid === 1'b1 && byte_out === prev_byte)) stab_err++;
    prev_hold = byte_out_valid && !byte_out_ready;
    prev_byte = byte_out;
    if ((byte_in_ready & ~oh(active)) !== '0) rdy_err++;
    pend_out   = byte_out_valid && byte_out_ready;
    pend_byte  = byte_out;
    pend_in    = byte_in_valid & byte_in_ready;
    pend_start = start_harvest;
    for (int i = 0; i < NG; i++) start_cnt[i] += int'(start_harvest[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NG; i++) begin
      gq[i].delete();
      g_st[i]   = 0;
      g_held[i] = 1'b0;
    end
    obs.delete();
    pend_out   = 1'b0;
    pend_in    = '0;
    pend_start = '0;
    prev_hold  = 1'b0;
    req_next   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    arst = 1'b1;
    clear_model();
    for (int k = 0; k < n; k++) step();
    arst = 1'b0;
    clear_model();
  endtask

  // Runs one harvest pass and compares against the expected framed byte stream.
  task automatic run_pass(input logic [NG-1:0] mask, input logic [NG-1:0] alive,
                          input int nb, input int rdy, input bit chk_lat,
                          input bit inject, input int abort_g);
    logic [7:0] exp_q[$];
    logic [7:0] t;
    bit         exp_terr, aborted;
    int         first, n, cyc;
    exp_terr = 1'b0;
    aborted  = 1'b0;
    first    = -1;
    clear_model();
    noise_mask = ~mask;
    stab_err   = 0;
    rdy_err    = 0;
    for (int i = 0; i < NG; i++) begin
      start_cnt[i] = 0;
      g_alive[i]   = alive[i];
      if (mask[i]) begin
        if (first < 0) first = i;
`ifdef GRABBER_SCHEDULER_HEADER_EN
        t = 8'hA0 | 8'(i);
        exp_q.push_back(t);
`endif
        if (alive[i]) begin
          n = (nb > 0) ? nb : $urandom_range(1, 4);
          for (int k = 0; k < n; k++) begin
            t = 8'($urandom);
            gq[i].push_back(t);
            exp_q.push_back(t);
          end
        end else begin
          exp_q.push_back(8'hEE);
          exp_terr = 1'b1;
        end
      end
    end
    rdy_mode = rdy;
    req_mask = mask;
    req_next = 1'b1;
    step();
    step();
    if (chk_lat) begin
      chk("busy_latency", busy, 1);
      chk("terr_cleared_on_req", timeout_err, 0);
`ifndef GRABBER_SCHEDULER_HEADER_EN
      chk("start_first", start_harvest, oh(first));
`endif
    end
    step();
`ifdef GRABBER_SCHEDULER_HEADER_EN
    if (chk_lat) begin
      chk("hdr_valid_latency", byte_out_valid, 1);
      chk("hdr_byte_first", byte_out, 32'hA0 | first);
      chk("start_first", start_harvest, oh(first));
    end
`endif
    cyc = 0;
    while (!(busy === 1'b0 && byte_out_valid === 1'b0) && cyc < 3000) begin
      if (inject && cyc == 3) begin
        chk("busy_at_second_req", busy, 1);
        req_next = 1'b1;
        req_mask = '1;
      end
      if (abort_g >= 0 && g_st[abort_g] == 2 && gq[abort_g].size() > 0 &&
          gq[abort_g].size() < nb) begin
        #2 arst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_start", start_harvest, 0);
        chk("abort_in_ready", byte_in_ready, 0);
        chk("abort_out_valid", byte_out_valid, 0);
        chk("abort_out_byte", byte_out, 0);
        chk("abort_terr", timeout_err, 0);
        do_reset(2);
        aborted = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    if (abort_g >= 0) begin
      chk("abort_reached", aborted, 1);
    end else begin
      chk("pass_done_in_budget", (cyc < 3000), 1);
      chk("byte_count", obs.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        chk($sformatf("byte_%0d", k), (k < obs.size()) ? obs[k] : 32'hFFFF_FFFF, exp_q[k]);
      end
      for (int i = 0; i < NG; i++) begin
        chk($sformatf("start_pulses_g%0d", i), start_cnt[i], mask[i] ? 1 : 0);
      end
      chk("out_stable_under_backpressure", stab_err, 0);
      chk("ready_only_for_selected", rdy_err, 0);
      chk("timeout_err_end", timeout_err, exp_terr);
      chk("busy_end", busy, 0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    logic [NG-1:0] m, al;
    int            busy_seen;
    harvest_req    = 1'b0;
    enable_mask    = '0;
    reporting      = '0;
    byte_in        = '0;
    byte_in_valid  = '0;
    byte_out_ready = 1'b0;
    noise_mask     = '1;
    active         = 0;
    rdy_mode       = 0;
    req_mask       = '0;
    for (int i = 0; i < NG; i++) begin
      g_alive[i] = 1'b1;
      g_dly[i]   = 0;
    end
    do_reset(3);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_harvest, 0);
    chk("rst_in_ready", byte_in_ready, 0);
    chk("rst_out_byte", byte_out, 0);
    chk("rst_out_valid", byte_out_valid, 0);
    chk("rst_terr", timeout_err, 0);

    // Basic pass, ready held high, three bytes per grabber.
    run_pass(4'b0101, '1, 3, 0, 1'b1, 1'b0, -1);
    // Same mask under random backpressure.
    run_pass(4'b0101, '1, 3, 1, 1'b1, 1'b0, -1);

    // Grabber 1 never reports.
    run_pass(4'b0011, 4'b1101, 3, 1, 1'b1, 1'b0, -1);
    for (int k = 0; k < 20; k++) step();
    chk("terr_sticky_idle", timeout_err, 1);
    run_pass(4'b1010, '1, 2, 0, 1'b1, 1'b0, -1);

    // Second request mid-pass is dropped.
    run_pass(4'b1111, '1, 3, 1, 1'b0, 1'b1, -1);

    // Zero mask: no pass.
    clear_model();
    noise_mask = '1;
    req_mask   = '0;
    req_next   = 1'b1;
    busy_seen  = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (busy !== 1'b0) busy_seen++;
    end
    chk("zero_mask_busy", busy_seen, 0);
    chk("zero_mask_bytes", obs.size(), 0);
    chk("zero_mask_out_valid", byte_out_valid, 0);

    // Reset during grabber 2 dump, then a clean pass.
    run_pass(4'b0111, '1, 4, 1, 1'b0, 1'b0, 2);
    run_pass(4'b0111, '1, 3, 1, 1'b1, 1'b0, -1);

    // Randomized passes.
    for (int r = 0; r < 6; r++) begin
      m = NG'($urandom_range(1, (1 << NG) - 1));
      al = '1;
      if ($urandom_range(0, 3) == 0) al = ~oh($urandom_range(0, NG - 1));
      run_pass(m, al, 0, $urandom_range(0, 1), 1'b1, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
